// File: rtl/bft_pkt_pkg.sv
// Shared BFT packet definitions: field widths, bit positions, packet struct
// and the packet builder used by the transmit-side packetizer.
package bft_pkt_pkg;

    localparam int PAYLOAD_BITS          = 32;
    localparam int NUM_LEAF_BITS         = 5;
    localparam int NUM_PORT_BITS         = 4;
    localparam int NUM_ADDR_BITS         = 7;
    localparam int PACKET_BITS           = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
    localparam int FREESPACE_UPDATE_SIZE = 64;

    localparam int ADDR_LSB  = PAYLOAD_BITS;
    localparam int PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
    localparam int VALID_BIT = LEAF_LSB + NUM_LEAF_BITS;

    // Credits equal the destination BRAM depth when the destination is empty
    localparam logic [NUM_ADDR_BITS:0] CREDIT_MAX = (NUM_ADDR_BITS+1)'(2**NUM_ADDR_BITS);

    typedef struct packed {
        logic                     valid;
        logic [NUM_LEAF_BITS-1:0] leaf;
        logic [NUM_PORT_BITS-1:0] port;
        logic [NUM_ADDR_BITS-1:0] addr;
        logic [PAYLOAD_BITS-1:0]  payload;
    } bft_pkt_t;

    // Builds a valid packet by placing each field at its wire position
    function automatic bft_pkt_t make_pkt(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [NUM_ADDR_BITS-1:0] addr,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        logic [PACKET_BITS-1:0] w;
        w                               = '0;
        w[VALID_BIT]                    = 1'b1;
        w[LEAF_LSB +: NUM_LEAF_BITS]    = leaf;
        w[PORT_LSB +: NUM_PORT_BITS]    = port;
        w[ADDR_LSB +: NUM_ADDR_BITS]    = addr;
        w[0 +: PAYLOAD_BITS]            = payload;
        return bft_pkt_t'(w);
    endfunction

endpackage

// File: rtl/stream_packetizer_if.sv
// Handshake bundle of the packetizer: operator-side ap_vld/ap_ack word port
// and arbiter-side packet valid/ready port. The slave modport is the packetizer.
interface stream_packetizer_if;
    import bft_pkt_pkg::*;

    logic [PAYLOAD_BITS-1:0] din_user;
    logic                    vld_user;
    logic                    ack_user;
    logic [PACKET_BITS-1:0]  pkt_dout;
    logic                    pkt_vld;
    logic                    pkt_rdy;

    modport master (
        output din_user, vld_user, pkt_rdy,
        input  ack_user, pkt_dout, pkt_vld
    );

    modport slave (
        input  din_user, vld_user, pkt_rdy,
        output ack_user, pkt_dout, pkt_vld
    );
endinterface

// File: rtl/pkt_fifo2.sv
// Two-entry FIFO of formed packets. entry0 is always the head; the output
// reads as zero while empty. Simultaneous push and pop is legal when full.
module pkt_fifo2 #(
    parameter int WIDTH = 49
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (cnt != 2'd0);
    assign push_ok = push && ((cnt != 2'd2) || pop_ok);
    assign dout    = (cnt != 2'd0) ? entry0 : '0;

    // Shift-style storage: pops move entry1 into the head, pushes fill the first free slot
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) entry0 <= din;
                    else             entry1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    entry1 <= '0;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stream_packetizer.sv
// Transmit-side BFT packetizer: turns operator words into addressed packets,
// tracks destination BRAM credits and the write address, and buffers up to
// two packets toward the interface arbiter.
// Optional: define PACKETIZER_STALL_CNT_EN to count zero-credit stall cycles
// on stall_cnt; otherwise stall_cnt is tied to zero.
module stream_packetizer
    import bft_pkt_pkg::*;
(
    input  logic                     clk_user,
    input  logic                     reset,
    stream_packetizer_if.slave       bus,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    input  logic                     credit_upd,
    output logic [15:0]              stall_cnt
);

    localparam logic [NUM_ADDR_BITS+1:0] CREDIT_UPD_W = (NUM_ADDR_BITS+2)'(FREESPACE_UPDATE_SIZE);

    logic [NUM_ADDR_BITS:0]   credits;
    logic [NUM_ADDR_BITS:0]   credits_next;
    logic [NUM_ADDR_BITS+1:0] credit_sum;
    logic [NUM_ADDR_BITS-1:0] addr_cnt;
    logic [1:0]               fifo_cnt;
    logic                     pop;
    logic                     credit_ok;
    logic                     ack;
    logic                     accept;
    bft_pkt_t                 push_pkt;

    assign pop       = (fifo_cnt != 2'd0) && bus.pkt_rdy;
    assign credit_ok = (credits != '0);
    assign ack       = !reset && ((fifo_cnt < 2'd2) || pop) && credit_ok;
    assign accept    = bus.vld_user && ack;
    assign push_pkt  = make_pkt(dest_leaf, dest_port, addr_cnt, bus.din_user);

    assign bus.ack_user = ack;
    assign bus.pkt_vld  = (fifo_cnt != 2'd0);

    pkt_fifo2 #(
        .WIDTH (PACKET_BITS)
    ) u_fifo (
        .clk   (clk_user),
        .reset (reset),
        .push  (accept),
        .din   (push_pkt),
        .pop   (pop),
        .dout  (bus.pkt_dout),
        .cnt   (fifo_cnt)
    );

    // Net credit change of the cycle (return minus consumption), clipped at the BRAM depth
    always_comb begin
        credit_sum   = {1'b0, credits}
                     + (credit_upd ? CREDIT_UPD_W : '0)
                     - {{(NUM_ADDR_BITS+1){1'b0}}, accept};
        credits_next = credit_sum[NUM_ADDR_BITS:0];
        if (credit_sum > {1'b0, CREDIT_MAX}) begin
            credits_next = CREDIT_MAX;
        end
    end

    // Credit and destination-address registers; the address wraps with the BRAM depth
    always_ff @(posedge clk_user) begin
        if (reset) begin
            credits  <= CREDIT_MAX;
            addr_cnt <= '0;
        end else begin
            credits <= credits_next;
            if (accept) begin
                addr_cnt <= addr_cnt + NUM_ADDR_BITS'(1);
            end
        end
    end

`ifdef PACKETIZER_STALL_CNT_EN
    logic [15:0] stall_q;

    // Counts cycles where the operator offers data but no credit is left
    always_ff @(posedge clk_user) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if (bus.vld_user && !credit_ok && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
